// File: rtl/dense_layer_mac_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dense_layer_mac_pkg
// Purpose  : Shared activation codes, FSM state type and a width helper for
//            the dense-layer MAC and its saturating activation unit.
// Revision : 1.0 - initial release
// ============================================================================
package dense_layer_mac_pkg;

  // Activation select codes; code 3 is reserved and behaves as none.
  localparam logic [1:0] c_ACT_NONE  = 2'd0;
  localparam logic [1:0] c_ACT_RELU  = 2'd1;
  localparam logic [1:0] c_ACT_LEAKY = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_ACT  = 2'd2
  } mac_state_t;

  // Ceiling log2, never below 1 so that a one-entry index still has a bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << k) < value) r = k + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_act_unit.sv
`default_nettype none
// ============================================================================
// Module   : sat_act_unit
// Purpose  : Combinational rescale, activation and saturation of one
//            accumulator value down to a DW-wide fixed-point result.
// Revision : 1.0 - initial release
// ============================================================================
module sat_act_unit
  import dense_layer_mac_pkg::*;
#(
  parameter int ACC_W      = 41,
  parameter int DW         = 16,
  parameter int FRAC       = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [1:0]       mode,
  output logic        [DW-1:0]    result,
  output logic                    sat
);

  localparam logic signed [ACC_W-1:0] c_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACC_W-1:0] w_v;
  logic signed [ACC_W-1:0] w_act;

  // Product sum carries 2*FRAC fractional bits; drop FRAC of them with floor.
  assign w_v = acc >>> FRAC;

  // Apply the selected activation to the rescaled value.
  always_comb begin
    w_act = w_v;
    case (mode)
      c_ACT_NONE:  w_act = w_v;
      c_ACT_RELU:  if (w_v[ACC_W-1]) w_act = '0;
      c_ACT_LEAKY: if (w_v[ACC_W-1]) w_act = w_v >>> LEAK_SHIFT;
      default:     w_act = w_v;
    endcase
  end

  // Clamp to the signed DW range and flag any clamping.
  always_comb begin
    result = w_act[DW-1:0];
    sat    = 1'b0;
    if (w_act > c_MAX) begin
      result = c_MAX[DW-1:0];
      sat    = 1'b1;
    end else if (w_act < c_MIN) begin
      result = c_MIN[DW-1:0];
      sat    = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dense_layer_mac.sv
`default_nettype none
// ============================================================================
// Module   : dense_layer_mac
// Purpose  : One fully-connected layer of N_OUT neurons over N_IN fixed-point
//            inputs on a single sequential MAC, with activation, saturation
//            and argmax. Weight/bias images come in as packed parameters,
//            row-major (n*N_IN+i), element k at [(k+1)*DW-1 -: DW].
// Revision : 1.0 - initial release
// ============================================================================
module dense_layer_mac
  import dense_layer_mac_pkg::*;
#(
  parameter int                        N_IN       = 256,
  parameter int                        N_OUT      = 16,
  parameter int                        DW         = 16,
  parameter int                        FRAC       = 8,
  parameter int                        LEAK_SHIFT = 3,
  parameter logic [N_OUT*N_IN*DW-1:0]  W_INIT     = '0,
  parameter logic [N_OUT*DW-1:0]       B_INIT     = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [1:0]                      act_mode,
  input  logic [N_IN*DW-1:0]              flat_input,
  output logic                            busy,
  output logic                            done,
  output logic [N_OUT*DW-1:0]             flat_output,
  output logic [clog2_min1(N_OUT)-1:0]    class_idx,
  output logic                            sat_flag
);

  localparam int c_IW    = clog2_min1(N_IN);
  localparam int c_NW    = clog2_min1(N_OUT);
  localparam int c_AW    = clog2_min1(N_OUT*N_IN);
  localparam int c_ACC_W = 2*DW + c_IW + 1;
  localparam int c_XW    = c_ACC_W - 2*DW;
  localparam logic [c_IW-1:0] c_I_LAST = c_IW'(N_IN-1);
  localparam logic [c_NW-1:0] c_N_LAST = c_NW'(N_OUT-1);

  logic signed [DW-1:0] w_wrom [N_OUT*N_IN];
  logic signed [DW-1:0] w_brom [N_OUT];

  mac_state_t              r_state;
  logic [c_IW-1:0]         r_i;
  logic [c_NW-1:0]         r_n;
  logic [c_AW-1:0]         r_waddr;
  logic signed [c_ACC_W-1:0] r_acc;
  logic signed [DW-1:0]    r_x [N_IN];
  logic [1:0]              r_mode;
  logic [DW-1:0]           r_work [N_OUT];
  logic [DW-1:0]           r_out [N_OUT];
  logic signed [DW-1:0]    r_max;
  logic [c_NW-1:0]         r_max_idx;
  logic                    r_sat_work;
  logic                    r_busy;
  logic                    r_done;
  logic [c_NW-1:0]         r_class;
  logic                    r_sat;

  logic signed [2*DW-1:0]    w_prod;
  logic signed [c_ACC_W-1:0] w_prod_ext;
  logic signed [c_ACC_W-1:0] w_bias0_acc;
  logic signed [c_ACC_W-1:0] w_bias_next_acc;
  logic [c_NW-1:0]           w_n_next;
  logic [DW-1:0]             w_res;
  logic                      w_sat;
  logic                      w_take;

  for (genvar k = 0; k < N_OUT*N_IN; k++) begin : g_wrom
    assign w_wrom[k] = W_INIT[k*DW +: DW];
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_brom
    assign w_brom[k] = B_INIT[k*DW +: DW];
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign flat_output[k*DW +: DW] = r_out[k];
  end

  // The flat weight address walks row-major straight through every neuron.
  assign w_prod          = r_x[r_i] * w_wrom[r_waddr];
  assign w_prod_ext      = {{c_XW{w_prod[2*DW-1]}}, w_prod};
  assign w_n_next        = r_n + c_NW'(1);
  assign w_bias0_acc     = {{(c_ACC_W-DW){w_brom[0][DW-1]}}, w_brom[0]} << FRAC;
  assign w_bias_next_acc = {{(c_ACC_W-DW){w_brom[w_n_next][DW-1]}}, w_brom[w_n_next]} << FRAC;

  // The first neuron always seeds the running max; later ones need strictly greater.
  assign w_take = (r_n == '0) || ($signed(w_res) > r_max);

  sat_act_unit #(
    .ACC_W      (c_ACC_W),
    .DW         (DW),
    .FRAC       (FRAC),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_sat_act (
    .acc    (r_acc),
    .mode   (r_mode),
    .result (w_res),
    .sat    (w_sat)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign class_idx = r_class;
  assign sat_flag  = r_sat;

  // Sequencer: latch a run, accumulate one product per cycle, then activate each neuron.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_i        <= '0;
      r_n        <= '0;
      r_waddr    <= '0;
      r_acc      <= '0;
      r_mode     <= c_ACT_NONE;
      r_max      <= '0;
      r_max_idx  <= '0;
      r_sat_work <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_class    <= '0;
      r_sat      <= 1'b0;
      for (int k = 0; k < N_IN; k++) r_x[k] <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        r_work[k] <= '0;
        r_out[k]  <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int k = 0; k < N_IN; k++) r_x[k] <= flat_input[k*DW +: DW];
            r_mode     <= act_mode;
            r_acc      <= w_bias0_acc;
            r_i        <= '0;
            r_n        <= '0;
            r_waddr    <= '0;
            r_sat_work <= 1'b0;
            r_max      <= '0;
            r_max_idx  <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc   <= r_acc + w_prod_ext;
          r_waddr <= r_waddr + c_AW'(1);
          if (r_i == c_I_LAST) begin
            r_state <= ST_ACT;
          end else begin
            r_i <= r_i + c_IW'(1);
          end
        end
        ST_ACT: begin
          r_work[r_n] <= w_res;
          r_sat_work  <= r_sat_work | w_sat;
          if (w_take) begin
            r_max     <= $signed(w_res);
            r_max_idx <= r_n;
          end
          if (r_n != c_N_LAST) begin
            r_acc   <= w_bias_next_acc;
            r_i     <= '0;
            r_n     <= w_n_next;
            r_state <= ST_MAC;
          end else begin
            // Publish the whole layer at once so readers never see a mix of runs.
            for (int k = 0; k < N_OUT-1; k++) r_out[k] <= r_work[k];
            r_out[N_OUT-1] <= w_res;
            r_class <= w_take ? r_n : r_max_idx;
            r_sat   <= r_sat_work | w_sat;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_dense_layer_mac
// Purpose  : Self-checking bench for dense_layer_mac: two small 4x2 layers
//            sharing stimulus plus one full-size 256x16 layer, checked against
//            an arithmetic reference model of the layer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dense_layer_mac;

  localparam logic [127:0] c_W_A = {8{16'h0100}};
  localparam logic [31:0]  c_B_A = 32'h0000_0000;
  localparam logic [127:0] c_W_B = {{4{16'hFF00}}, {4{16'h0100}}};
  localparam logic [31:0]  c_B_B = {16'h0100, 16'h0000};

  // Full-size weights: a 17-word pattern repeated, so every neuron row differs.
  localparam logic [271:0] c_PAT = {16'h0123, 16'hFE45, 16'h0087, 16'hFFC2, 16'h01A9,
                                    16'hFE10, 16'h0033, 16'h0155, 16'hFF7E, 16'h00F1,
                                    16'hFE99, 16'h0010, 16'h01FF, 16'hFF01, 16'h0068,
                                    16'hFED4, 16'h00BB};
  localparam logic [241*272-1:0] c_REP = {241{c_PAT}};
  localparam logic [65535:0] c_W_D = c_REP[65535:0];
  localparam logic [255:0]   c_B_D = {16'h0100, 16'hFC00, 16'h0000, 16'h0380, 16'hFF40, 16'h0040,
                                      16'h0200, 16'hFE00, 16'h0011, 16'hFFEE, 16'h03FF, 16'hFC01,
                                      16'h0080, 16'hFF80, 16'h0155, 16'hFEAB};

  localparam logic [63:0] c_X1   = {16'hFF00, 16'h0300, 16'h0200, 16'h0100};
  localparam logic [63:0] c_XSAT = {4{16'h7FFF}};
  localparam logic [63:0] c_JUNK = {16'h1234, 16'h8000, 16'h7000, 16'h0F0F};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start_s = 1'b0;
  logic [1:0]  mode_s  = 2'd0;
  logic [63:0] in_s    = '0;
  logic        busy_a, done_a, sat_a, cls_a;
  logic        busy_b, done_b, sat_b, cls_b;
  logic [31:0] out_a, out_b;

  logic          start_d = 1'b0;
  logic [1:0]    mode_d  = 2'd0;
  logic [4095:0] in_d    = '0;
  logic          busy_d, done_d, sat_d;
  logic [255:0]  out_d;
  logic [3:0]    cls_d;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dense_layer_mac #(.N_IN(4), .N_OUT(2), .DW(16), .FRAC(8), .LEAK_SHIFT(3),
                    .W_INIT(c_W_A), .B_INIT(c_B_A)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_s), .act_mode(mode_s), .flat_input(in_s),
    .busy(busy_a), .done(done_a), .flat_output(out_a), .class_idx(cls_a), .sat_flag(sat_a));

  dense_layer_mac #(.N_IN(4), .N_OUT(2), .DW(16), .FRAC(8), .LEAK_SHIFT(3),
                    .W_INIT(c_W_B), .B_INIT(c_B_B)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_s), .act_mode(mode_s), .flat_input(in_s),
    .busy(busy_b), .done(done_b), .flat_output(out_b), .class_idx(cls_b), .sat_flag(sat_b));

  dense_layer_mac #(.N_IN(256), .N_OUT(16), .DW(16), .FRAC(8), .LEAK_SHIFT(3),
                    .W_INIT(c_W_D), .B_INIT(c_B_D)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_d), .act_mode(mode_d), .flat_input(in_d),
    .busy(busy_d), .done(done_d), .flat_output(out_d), .class_idx(cls_d), .sat_flag(sat_d));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference layer: exact integer sums, floor rescale, activation, clamp, argmax.
  function automatic void model(input logic [65535:0] w, input logic [255:0] b,
                                input logic [4095:0] x, input int nin, input int nout,
                                input logic [1:0] m, output logic [255:0] outs,
                                output int idx, output bit sat);
    longint acc, v, best;
    outs = '0;
    idx  = 0;
    sat  = 1'b0;
    best = 0;
    for (int n = 0; n < nout; n++) begin
      acc = longint'($signed(b[n*16 +: 16])) * 256;
      for (int i = 0; i < nin; i++)
        acc += longint'($signed(x[i*16 +: 16])) * longint'($signed(w[(n*nin+i)*16 +: 16]));
      v = acc >>> 8;
      if (m == 2'd1 && v < 0) v = 0;
      else if (m == 2'd2 && v < 0) v = v >>> 3;
      if (v > 32767) begin v = 32767; sat = 1'b1; end
      if (v < -32768) begin v = -32768; sat = 1'b1; end
      outs[n*16 +: 16] = v[15:0];
      if (n == 0 || v > best) begin best = v; idx = n; end
    end
  endfunction

  task automatic start_small(input logic [63:0] x, input logic [1:0] m);
    @(negedge clk);
    in_s = x; mode_s = m; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
  endtask

  // Counts edges after the accept edge until done, and cycles busy was seen high.
  task automatic wait_small(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = busy_a ? 1 : 0;
    while (!done_a && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (busy_a) bcnt++;
    end
  endtask

  task automatic check_small(input string tag, input logic [63:0] x, input logic [1:0] m);
    logic [255:0] eo;
    int ei;
    bit es;
    model(65536'(c_W_A), 256'(c_B_A), 4096'(x), 4, 2, m, eo, ei, es);
    check({tag, "/a_out0"}, 64'(out_a[15:0]), 64'(eo[15:0]));
    check({tag, "/a_out1"}, 64'(out_a[31:16]), 64'(eo[31:16]));
    check({tag, "/a_cls"}, 64'(cls_a), 64'(ei));
    check({tag, "/a_sat"}, 64'(sat_a), 64'(es));
    model(65536'(c_W_B), 256'(c_B_B), 4096'(x), 4, 2, m, eo, ei, es);
    check({tag, "/b_out0"}, 64'(out_b[15:0]), 64'(eo[15:0]));
    check({tag, "/b_out1"}, 64'(out_b[31:16]), 64'(eo[31:16]));
    check({tag, "/b_cls"}, 64'(cls_b), 64'(ei));
    check({tag, "/b_sat"}, 64'(sat_b), 64'(es));
    check({tag, "/b_done"}, 64'(done_b), 64'd1);
  endtask

  task automatic run_big(input logic [1:0] m, input int span);
    logic [4095:0] x;
    logic [255:0] eo;
    int ei, v, cyc;
    bit es;
    for (int i = 0; i < 256; i++) begin
      v = int'($urandom_range(0, 2*span-1)) - span;
      x[i*16 +: 16] = v[15:0];
    end
    @(negedge clk);
    in_d = x; mode_d = m; start_d = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    cyc = 0;
    while (!done_d && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("big_m%0d/latency", m), 64'(cyc), 64'd4112);
    model(c_W_D, c_B_D, x, 256, 16, m, eo, ei, es);
    for (int n = 0; n < 16; n++)
      check($sformatf("big_m%0d/out%0d", m, n), 64'(out_d[n*16 +: 16]), 64'(eo[n*16 +: 16]));
    check($sformatf("big_m%0d/cls", m), 64'(cls_d), 64'(ei));
    check($sformatf("big_m%0d/sat", m), 64'(sat_d), 64'(es));
  endtask

  initial begin
    int cyc, bcnt, dcnt;
    logic [63:0] x;
    logic [1:0] m;
    int v;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst/a_busy", 64'(busy_a), 64'd0);
    check("rst/a_done", 64'(done_a), 64'd0);
    check("rst/a_out", 64'(out_a), 64'd0);
    check("rst/a_cls", 64'(cls_a), 64'd0);
    check("rst/a_sat", 64'(sat_a), 64'd0);
    check("rst/d_out_lo", out_d[63:0], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: uniform weights and the mixed-sign second layer, all three modes.
    start_small(c_X1, 2'd0);
    wait_small(cyc, bcnt);
    check("c1/latency", 64'(cyc), 64'd10);
    check("c1/busy_cycles", 64'(bcnt), 64'd10);
    check("c1/a_out", 64'(out_a), 64'h0500_0500);
    check("c1/a_cls_tie", 64'(cls_a), 64'd0);
    check("c1/a_sat", 64'(sat_a), 64'd0);
    check("c2m0/b_out", 64'(out_b), 64'hFC00_0500);
    check("c2m0/b_cls", 64'(cls_b), 64'd0);
    @(posedge clk); #1;
    check("c1/done_pulse", 64'(done_a), 64'd0);

    start_small(c_X1, 2'd1);
    wait_small(cyc, bcnt);
    check("c2m1/b_out1", 64'(out_b[31:16]), 64'h0000);
    start_small(c_X1, 2'd2);
    wait_small(cyc, bcnt);
    check("c2m2/b_out1", 64'(out_b[31:16]), 64'hFF80);
    check_small("c2m2", c_X1, 2'd2);

    // Saturation, then a clean run clears the flag.
    start_small(c_XSAT, 2'd0);
    wait_small(cyc, bcnt);
    check("c3/a_out", 64'(out_a), 64'h7FFF_7FFF);
    check("c3/a_sat", 64'(sat_a), 64'd1);
    check_small("c3", c_XSAT, 2'd0);
    start_small(c_X1, 2'd0);
    wait_small(cyc, bcnt);
    check("c3b/a_sat", 64'(sat_a), 64'd0);

    // Start pulses at edges 3 and 7 with other data are ignored.
    start_small(c_X1, 2'd0);
    cyc = 0;
    while (!done_a && cyc < 100) begin
      start_s = (cyc == 2 || cyc == 6);
      if (start_s) in_s = c_JUNK;
      @(posedge clk); #1;
      cyc++;
    end
    start_s = 1'b0;
    check("c4/latency", 64'(cyc), 64'd10);
    check("c4/a_out", 64'(out_a), 64'h0500_0500);
    // Start in the done cycle: accepted with no bubble.
    in_s = c_XSAT; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    check("c4/done_one_cycle", 64'(done_a), 64'd0);
    check("c4/b2b_busy", 64'(busy_a), 64'd1);
    wait_small(cyc, bcnt);
    check("c4/b2b_latency", 64'(cyc), 64'd10);
    check("c4/b2b_out", 64'(out_a), 64'h7FFF_7FFF);

    // Reset in the middle of a run aborts it.
    start_small(c_X1, 2'd0);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("c5/busy", 64'(busy_a), 64'd0);
    check("c5/done", 64'(done_a), 64'd0);
    check("c5/out", 64'(out_a), 64'd0);
    check("c5/sat", 64'(sat_a), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done_a) dcnt++;
    end
    check("c5/no_done", 64'(dcnt), 64'd0);
    start_small(c_X1, 2'd0);
    wait_small(cyc, bcnt);
    check("c5/rerun_latency", 64'(cyc), 64'd10);
    check("c5/rerun_out", 64'(out_a), 64'h0500_0500);

    // Random small runs against the model.
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 65535));
        else v = int'($urandom_range(0, 2047)) - 1024;
        x[i*16 +: 16] = v[15:0];
      end
      m = 2'($urandom_range(0, 3));
      start_small(x, m);
      wait_small(cyc, bcnt);
      check($sformatf("rnd%0d/latency", r), 64'(cyc), 64'd10);
      check_small($sformatf("rnd%0d", r), x, m);
    end

    // Full-size layer.
    run_big(2'd0, 512);
    run_big(2'd1, 512);
    run_big(2'd2, 2048);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
